// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: issues pixel/weight read addresses for every neuron word, aligns
// accumulator clear/enable with the MAC pipeline and tracks a signed argmax.
`default_nettype none

module mac_seq_ctrl #(
  parameter int WORDS    = 4,
  parameter int NEURONS  = 10,
  parameter int PIPE_LAT = 4,
  parameter int ADDR_W   = 6,
  parameter int IMG_W    = 4,
  parameter int ACC_W    = 22
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [IMG_W-1:0]  img_sel_i,
  input  logic [ACC_W-1:0]  acc_dout_i,
  output logic [ADDR_W-1:0] addr_p_o,
  output logic [ADDR_W-1:0] addr_w_o,
  output logic              addr_vld_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic [3:0]        nrn_idx_o,
  output logic              res_vld_o,
  output logic [3:0]        res_idx_o,
  output logic [ACC_W-1:0]  res_val_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        class_out_o,
  output logic [ACC_W-1:0]  max_val_o
);

  localparam int TOTAL  = NEURONS * WORDS;
  localparam int CNT_MN = $clog2(TOTAL) + 1;
  localparam int CNT_W  = (CNT_MN > ADDR_W) ? CNT_MN : ADDR_W;
  localparam int WRD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WRD_W-1:0]   wrd_q, wrd_d;
  logic [3:0]         nrn_q, nrn_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic               vld_q, vld_d;

  logic [PIPE_LAT-1:0]      pv_q, pf_q, pl_q;
  logic [PIPE_LAT-1:0][3:0] pn_q;

  logic               cap_q;
  logic [3:0]         cap_idx_q;
  logic               res_vld_q;
  logic [3:0]         res_idx_q;
  logic [ACC_W-1:0]   res_val_q;
  logic [3:0]         best_idx_q, best_idx_nx;
  logic [ACC_W-1:0]   best_val_q, best_val_nx;
  logic [3:0]         class_q;
  logic [ACC_W-1:0]   max_q;

  logic last_issue, finish, take;

  assign last_issue = (cnt_q == CNT_W'(TOTAL - 1));
  assign finish     = (state_q == S_DRAIN) && res_vld_q && (res_idx_q == 4'(NEURONS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrd_d   = wrd_q;
    nrn_d   = nrn_q;
    img_d   = img_q;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          img_d   = img_sel_i;
          cnt_d   = '0;
          wrd_d   = '0;
          nrn_d   = '0;
          vld_d   = 1'b1;
        end
      end
      S_FETCH: begin
        if (last_issue) begin
          state_d = S_DRAIN;
        end else begin
          vld_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (wrd_q == WRD_W'(WORDS - 1)) begin
            wrd_d = '0;
            nrn_d = nrn_q + 1'b1;
          end else begin
            wrd_d = wrd_q + 1'b1;
          end
        end
      end
      S_DRAIN: if (finish) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wrd_q   <= '0;
      nrn_q   <= '0;
      img_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrd_q   <= wrd_d;
      nrn_q   <= nrn_d;
      img_q   <= img_d;
      vld_q   <= vld_d;
    end
  end

  // Stage 0 is loaded from the issue cycle, so the last stage lines up PIPE_LAT cycles later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
      pn_q <= '0;
    end else begin
      pv_q[0] <= vld_q;
      pf_q[0] <= (wrd_q == '0);
      pl_q[0] <= (wrd_q == WRD_W'(WORDS - 1));
      pn_q[0] <= nrn_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
        pn_q[i] <= pn_q[i-1];
      end
    end
  end

  assign take        = res_vld_q && ((res_idx_q == '0) || ($signed(res_val_q) > $signed(best_val_q)));
  assign best_idx_nx = take ? res_idx_q : best_idx_q;
  assign best_val_nx = take ? res_val_q : best_val_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_q      <= 1'b0;
      cap_idx_q  <= '0;
      res_vld_q  <= 1'b0;
      res_idx_q  <= '0;
      res_val_q  <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      class_q    <= '0;
      max_q      <= '0;
    end else begin
      cap_q      <= acc_en_o & pl_q[PIPE_LAT-1];
      cap_idx_q  <= nrn_idx_o;
      res_vld_q  <= cap_q;
      if (cap_q) begin
        res_val_q <= acc_dout_i;
        res_idx_q <= cap_idx_q;
      end
      best_idx_q <= best_idx_nx;
      best_val_q <= best_val_nx;
      if (finish) begin
        class_q <= best_idx_nx;
        max_q   <= best_val_nx;
      end
    end
  end

  assign addr_p_o    = ADDR_W'(img_q) * ADDR_W'(WORDS) + ADDR_W'(wrd_q);
  assign addr_w_o    = cnt_q[ADDR_W-1:0];
  assign addr_vld_o  = vld_q;
  assign acc_en_o    = pv_q[PIPE_LAT-1];
  assign acc_clr_o   = pv_q[PIPE_LAT-1] & pf_q[PIPE_LAT-1];
  assign nrn_idx_o   = pn_q[PIPE_LAT-1];
  assign res_vld_o   = res_vld_q;
  assign res_idx_o   = res_idx_q;
  assign res_val_o   = res_val_q;
  assign busy_o      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign class_out_o = class_q;
  assign max_val_o   = max_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: drives mac_seq_ctrl with a behavioural accumulator and checks
// every output cycle-by-cycle against a schedule derived from the sequencing rules.
`timescale 1ns/1ps

module tb_mac_seq_ctrl;

  localparam int W = 4, N = 10, PL = 4, AW = 6, IW = 4, AC = 22;
  localparam int TOTAL  = W * N;
  localparam int DONE_C = TOTAL + PL + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [IW-1:0] img;
  logic signed [AC-1:0] acc;
  logic [AW-1:0] ap, aw;
  logic          av, clr, en, rv, busy, done;
  logic [3:0]    nidx, ridx, cls;
  logic [AC-1:0] rval, mx;

  logic          startB;
  logic signed [AC-1:0] accB;
  logic [AW-1:0] apB, awB;
  logic          avB, clrB, enB, rvB, busyB, doneB;
  logic [3:0]    nidxB, ridxB, clsB;
  logic [AC-1:0] rvalB, mxB;

  int vectors = 0, errors = 0;
  int tgt [N];
  int piece [N][W];
  int tgtB [3] = '{1, 3, 2};
  int wc;
  logic [3:0]    prev_cls = '0;
  logic [AC-1:0] prev_mx  = '0;

  mac_seq_ctrl #(.WORDS(W), .NEURONS(N), .PIPE_LAT(PL), .ADDR_W(AW), .IMG_W(IW), .ACC_W(AC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .img_sel_i(img), .acc_dout_i(acc),
    .addr_p_o(ap), .addr_w_o(aw), .addr_vld_o(av), .acc_clr_o(clr), .acc_en_o(en),
    .nrn_idx_o(nidx), .res_vld_o(rv), .res_idx_o(ridx), .res_val_o(rval),
    .busy_o(busy), .done_o(done), .class_out_o(cls), .max_val_o(mx));

  mac_seq_ctrl #(.WORDS(1), .NEURONS(3), .PIPE_LAT(1), .ADDR_W(AW), .IMG_W(IW), .ACC_W(AC)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(startB), .img_sel_i(4'd0), .acc_dout_i(accB),
    .addr_p_o(apB), .addr_w_o(awB), .addr_vld_o(avB), .acc_clr_o(clrB), .acc_en_o(enB),
    .nrn_idx_o(nidxB), .res_vld_o(rvB), .res_idx_o(ridxB), .res_val_o(rvalB),
    .busy_o(busyB), .done_o(doneB), .class_out_o(clsB), .max_val_o(mxB));

  // Accumulator stand-in: each neuron's WORDS partial sums add up to its target.
  function automatic int pc(input logic [3:0] n, input int w);
    return (n < N) ? piece[n][w % W] : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      wc  <= 0;
    end else if (en) begin
      if (clr) begin
        acc <= AC'(pc(nidx, 0));
        wc  <= 1;
      end else begin
        acc <= acc + AC'(pc(nidx, wc));
        wc  <= wc + 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) accB <= '0;
    else if (enB) accB <= AC'(tgtB[(nidxB < 3) ? nidxB : 0]);
  end

  task automatic make_pieces();
    for (int n = 0; n < N; n++) begin
      int s = 0;
      for (int w = 0; w < W - 1; w++) begin
        piece[n][w] = int'($urandom_range(0, 2000)) - 1000;
        s += piece[n][w];
      end
      piece[n][W-1] = tgt[n] - s;
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({ap, aw, av, clr, en, nidx, rv, ridx, rval, busy, done, cls, mx} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not all zero, addr_w=%0d vld=%0b en=%0b busy=%0b done=%0b class=%0d max=%0h",
               tag, aw, av, en, busy, done, cls, mx);
    end
  endtask

  // One run from cycle 0 (caller is at edge+1 with the DUT idle) through the done cycle.
  task automatic run_check(input bit hold, input logic [IW-1:0] im);
    int best = 0;
    for (int n = 1; n < N; n++) if (tgt[n] > tgt[best]) best = n;
    make_pieces();
    start = 1'b1;
    img   = im;
    for (int c = 1; c <= DONE_C; c++) begin
      int ka, ke, kr;
      bit en_x, rv_x;
      @(posedge clk); #1;
      if (!hold) start = (c == 20 || c == DONE_C);
      ka   = (c <= TOTAL) ? c - 1 : TOTAL - 1;
      ke   = c - 1 - PL;
      kr   = c - 3 - PL;
      en_x = (ke >= 0) && (ke < TOTAL);
      rv_x = (kr >= 0) && (kr < TOTAL) && (kr % W == W - 1);
      vectors += 8;
      if (av !== (c <= TOTAL)) begin errors++; $display("FAIL addr_vld c%0d: got %0b want %0b", c, av, c <= TOTAL); end
      if (aw !== AW'(ka)) begin errors++; $display("FAIL addr_w c%0d: got %0d want %0d", c, aw, ka); end
      if (ap !== AW'(int'(im) * W + ka % W)) begin errors++; $display("FAIL addr_p c%0d: got %0d want %0d", c, ap, AW'(int'(im) * W + ka % W)); end
      if (en !== en_x) begin errors++; $display("FAIL acc_en c%0d: got %0b want %0b", c, en, en_x); end
      if (clr !== (en_x && ke % W == 0)) begin errors++; $display("FAIL acc_clr c%0d: got %0b want %0b", c, clr, en_x && ke % W == 0); end
      if (rv !== rv_x) begin errors++; $display("FAIL res_vld c%0d: got %0b want %0b", c, rv, rv_x); end
      if (done !== (c == DONE_C)) begin errors++; $display("FAIL done c%0d: got %0b want %0b", c, done, c == DONE_C); end
      if (busy !== (c < DONE_C)) begin errors++; $display("FAIL busy c%0d: got %0b want %0b", c, busy, c < DONE_C); end
      if (en_x) begin
        vectors++;
        if (nidx !== 4'(ke / W)) begin errors++; $display("FAIL nrn_idx c%0d: got %0d want %0d", c, nidx, ke / W); end
      end
      if (rv_x) begin
        vectors += 2;
        if (ridx !== 4'(kr / W)) begin errors++; $display("FAIL res_idx c%0d: got %0d want %0d", c, ridx, kr / W); end
        if (rval !== AC'(tgt[kr / W])) begin errors++; $display("FAIL res_val c%0d: got %0h want %0h", c, rval, AC'(tgt[kr / W])); end
      end
      if (c == DONE_C) begin
        prev_cls = 4'(best);
        prev_mx  = AC'(tgt[best]);
      end
      vectors += 2;
      if (cls !== prev_cls) begin errors++; $display("FAIL class_out c%0d: got %0d want %0d", c, cls, prev_cls); end
      if (mx !== prev_mx) begin errors++; $display("FAIL max_val c%0d: got %0h want %0h", c, mx, prev_mx); end
    end
    @(posedge clk); #1;
    vectors += 3;
    if (done !== 1'b0 || busy !== 1'b0 || av !== 1'b0) begin
      errors++; $display("FAIL post_done: done=%0b busy=%0b vld=%0b want 0 0 0", done, busy, av);
    end
    if (cls !== prev_cls) begin errors++; $display("FAIL class_hold: got %0d want %0d", cls, prev_cls); end
    if (mx !== prev_mx) begin errors++; $display("FAIL max_hold: got %0h want %0h", mx, prev_mx); end
    if (!hold) begin
      start = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || av !== 1'b0) begin
        errors++; $display("FAIL start_in_done_ignored: busy=%0b vld=%0b want 0 0", busy, av);
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b0; img = '0; startB = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_release");
  endtask

  task automatic test_basic();
    tgt = '{5, -3, 17, 9, 17, 0, -1, 2, 16, 4};
    run_check(1'b0, 4'd2);
  endtask

  task automatic test_negative();
    for (int n = 0; n < N; n++) tgt[n] = -100 + n;
    tgt[7] = -12;
    run_check(1'b0, 4'(IW'($urandom_range(0, 15))));
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < N; n++) tgt[n] = int'($urandom_range(0, 1000000)) - 500000;
      if (r == 2) begin
        int a = int'($urandom_range(0, 4));
        int b = int'($urandom_range(5, 9));
        tgt[a] = 600000;
        tgt[b] = 600000;
      end
      run_check(1'b0, 4'(IW'($urandom)));
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < N; n++) tgt[n] = int'($urandom_range(0, 4000)) - 2000;
      run_check(1'b1, 4'(IW'($urandom)));
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < N; n++) tgt[n] = int'($urandom_range(0, 4000)) - 2000;
    make_pieces();
    start = 1'b1;
    img   = 4'(IW'($urandom));
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    rst_n = 1'b1;
    prev_cls = '0;
    prev_mx  = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abandoned_run c%0d: done=%0b busy=%0b want 0 0", c, done, busy);
      end
    end
    for (int n = 0; n < N; n++) tgt[n] = int'($urandom_range(0, 4000)) - 2000;
    run_check(1'b0, 4'(IW'($urandom)));
  endtask

  task automatic test_small();
    startB = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      startB = 1'b0;
      vectors += 4;
      if (enB !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL small_en c%0d: got %0b want %0b", c, enB, c >= 2 && c <= 4); end
      if (clrB !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL small_clr c%0d: got %0b want %0b", c, clrB, c >= 2 && c <= 4); end
      if (rvB !== (c >= 4 && c <= 6)) begin errors++; $display("FAIL small_res_vld c%0d: got %0b want %0b", c, rvB, c >= 4 && c <= 6); end
      if (doneB !== (c == 7)) begin errors++; $display("FAIL small_done c%0d: got %0b want %0b", c, doneB, c == 7); end
      if (c >= 2 && c <= 4) begin
        vectors++;
        if (nidxB !== 4'(c - 2)) begin errors++; $display("FAIL small_nrn c%0d: got %0d want %0d", c, nidxB, c - 2); end
      end
      if (c == 7) begin
        vectors += 2;
        if (clsB !== 4'd1) begin errors++; $display("FAIL small_class: got %0d want 1", clsB); end
        if (mxB !== AC'(3)) begin errors++; $display("FAIL small_max: got %0h want 3", mxB); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
